// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake input controller:
//   - direction encodings (UP/RIGHT/DOWN/LEFT)
//   - PS/2 set-2 scancodes for WASD, arrow keys, space and R
//   - run/pause state encodings
//   - decoded key command type, scancode decoder and opposite-direction helper
// -----------------------------------------------------------------------------
package snake_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_R     = 8'h2D;

   localparam logic ST_RUN    = 1'b0;
   localparam logic ST_PAUSED = 1'b1;

   typedef enum logic [1:0] {
      CMD_NONE,
      CMD_DIR,
      CMD_PAUSE,
      CMD_RESTART
   } cmd_kind_t;

   typedef struct packed {
      cmd_kind_t  kind;
      logic [1:0] dir;
   } key_cmd_t;

   // Encodings are arranged so the reverse direction differs only in bit 1.
   function automatic logic [1:0] opposite_dir(input logic [1:0] d);
      return d ^ 2'b10;
   endfunction

   function automatic key_cmd_t decode_scancode(input logic [7:0] sc);
      key_cmd_t c;
      c.kind = CMD_NONE;
      c.dir  = DIR_UP;
      case (sc)
         SC_W, SC_UP: begin
            c.kind = CMD_DIR;
            c.dir  = DIR_UP;
         end
         SC_S, SC_DOWN: begin
            c.kind = CMD_DIR;
            c.dir  = DIR_DOWN;
         end
         SC_A, SC_LEFT: begin
            c.kind = CMD_DIR;
            c.dir  = DIR_LEFT;
         end
         SC_D, SC_RIGHT: begin
            c.kind = CMD_DIR;
            c.dir  = DIR_RIGHT;
         end
         SC_SPACE: c.kind = CMD_PAUSE;
         SC_R:     c.kind = CMD_RESTART;
         default:  c.kind = CMD_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/snake_input_ctrl_dir_fifo.sv
// -----------------------------------------------------------------------------
// dir_fifo
// Small synchronous FIFO of 2-bit direction codes.
//   clk, rst : system clock, synchronous active-high reset
//   push     : write din (accepted when not full, or when a pop frees a slot)
//   pop      : remove head (ignored when empty)
//   flush    : empty the queue (synchronous, takes priority over push/pop)
//   din      : direction to enqueue
//   head     : oldest entry (valid when not empty)
//   tail     : most recently written entry (valid when not empty)
//   count    : occupancy, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module dir_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [1:0]               din,
   output logic [1:0]               head,
   output logic [1:0]               tail,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [1:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_prev;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full queue can still accept.
   assign do_push = push & (~full | do_pop);

   assign wr_prev = wr_ptr - AW'(1);
   assign head    = mem[rd_ptr];
   assign tail    = mem[wr_prev];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once written.
   always_ff @(posedge clk) begin
      if (!rst && !flush && do_push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/snake_input_ctrl.sv
// -----------------------------------------------------------------------------
// snake_input_ctrl
// Bridges the PS/2 receiver to the snake game: synchronises the key-release
// strobe, decodes scancodes into direction / pause / restart commands, filters
// illegal turns, queues direction changes and releases one per game tick.
//   clk          : system clock
//   rst          : synchronous reset, active-high
//   key_pressed  : receiver release strobe (PS/2 clock domain)
//   last_pressed : receiver scancode, stable while key_pressed is high
//   tick         : one-cycle game-step request
//   dir          : current direction (0 UP, 1 RIGHT, 2 DOWN, 3 LEFT)
//   step         : one-cycle pulse, advance snake using dir
//   paused       : game paused
//   restart      : one-cycle pulse, restart requested
//   overflow     : one-cycle pulse, direction dropped because queue full
//   q_count      : direction queue occupancy
// -----------------------------------------------------------------------------
module snake_input_ctrl
   import snake_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [1:0]  INIT_DIR = 2'd1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   key_pressed,
   input  logic [7:0]             last_pressed,
   input  logic                   tick,
   output logic [1:0]             dir,
   output logic                   step,
   output logic                   paused,
   output logic                   restart,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] q_count
);

   // ---------------- input capture ----------------
   logic       sync_meta;
   logic       sync_key;
   logic       key_prev;
   logic       key_edge;
   logic       evt_valid;
   logic [7:0] evt_code;

   assign key_edge = sync_key & ~key_prev;

   // ---------------- decode / filter ----------------
   key_cmd_t   cmd;
   logic       is_dir;
   logic       is_pause;
   logic       is_restart;
   logic       state;
   logic       running;
   logic [1:0] ref_dir;
   logic       dir_legal;
   logic       want_push;
   logic       do_tick;
   logic       drop_full;

   // ---------------- queue ----------------
   logic [1:0] fifo_head;
   logic [1:0] fifo_tail;
   logic       fifo_full;
   logic       fifo_empty;

   assign cmd        = decode_scancode(evt_code);
   assign is_dir     = evt_valid && (cmd.kind == CMD_DIR);
   assign is_pause   = evt_valid && (cmd.kind == CMD_PAUSE);
   assign is_restart = evt_valid && (cmd.kind == CMD_RESTART);
   assign running    = (state == ST_RUN);

   // Compare against where the snake will be heading once everything already
   // queued has been applied, not against the current direction.
   assign ref_dir   = fifo_empty ? dir : fifo_tail;
   assign dir_legal = (cmd.dir != ref_dir) && (cmd.dir != opposite_dir(ref_dir));
   assign want_push = is_dir && running && dir_legal;

   assign do_tick   = tick && running && !is_restart;
   // When full, the queue is non-empty, so a concurrent tick always frees a slot.
   assign drop_full = want_push && fifo_full && !do_tick;

   assign paused  = (state == ST_PAUSED);

   dir_fifo #(
      .DEPTH (DEPTH)
   ) u_dir_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (want_push),
      .pop   (do_tick),
      .flush (is_restart),
      .din   (cmd.dir),
      .head  (fifo_head),
      .tail  (fifo_tail),
      .count (q_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_meta <= 1'b0;
         sync_key  <= 1'b0;
         key_prev  <= 1'b0;
         evt_valid <= 1'b0;
         evt_code  <= '0;
         dir       <= INIT_DIR;
         state     <= ST_RUN;
         step      <= 1'b0;
         restart   <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         sync_meta <= key_pressed;
         sync_key  <= sync_meta;
         key_prev  <= sync_key;
         evt_valid <= key_edge;
         // last_pressed has been stable since before key_pressed rose, so it
         // is safe to sample directly once the synchronised edge is seen.
         if (key_edge) begin
            evt_code <= last_pressed;
         end

         step     <= do_tick;
         restart  <= is_restart;
         overflow <= drop_full;

         if (is_restart) begin
            dir   <= INIT_DIR;
            state <= ST_RUN;
         end else begin
            if (do_tick && !fifo_empty) begin
               dir <= fifo_head;
            end
            if (is_pause) begin
               state <= running ? ST_PAUSED : ST_RUN;
            end
         end
      end
   end

endmodule
